mc_go_initiator: RTL and testbench

Initiator side of the go/change multi-cycle handshake used between the CPU test controller and variable-latency functional units. It accepts a request from an upstream valid/ready source and raises a registered `go` to the unit. It holds `go` until the unit's `change` (done) level is sampled, or until a timeout expires, then returns a response carrying the request tag, the measured latency and a timeout flag. It also keeps saturating completion and timeout statistics for the test bench.

---
 rtl/mc_go_if.sv | 29 ++
 rtl/mc_go_initiator.sv | 109 ++++++++++
 tb/tb_mc_go_initiator.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mc_go_if.sv
// go/change handshake bundle: upstream request, unit go/change,
// downstream response.
interface mc_go_if #(
  parameter int DATA_W = 32,
  parameter int LAT_W  = 4
);
  logic              req_valid;
  logic              req_ready;
  logic [DATA_W-1:0] req_data;
  logic              go;
  logic              change;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic [LAT_W-1:0]  rsp_lat;
  logic              rsp_timeout;

  modport master (
    input  req_valid, req_data, change, rsp_ready,
    output req_ready, go, rsp_valid, rsp_data,
    output rsp_lat, rsp_timeout
  );

  modport slave (
    output req_valid, req_data, change, rsp_ready,
    input  req_ready, go, rsp_valid, rsp_data,
    input  rsp_lat, rsp_timeout
  );
endinterface

// File: rtl/mc_go_initiator.sv
// Go/change initiator: holds go until change or timeout, then
// returns tag, latency and timeout flag; keeps saturating stats.
module mc_go_initiator #(
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15,
  parameter int LAT_W   = 4
) (
  input  logic        clk,
  input  logic        rst,
  mc_go_if.master     b,
  output logic        busy,
  output logic [15:0] done_cnt,
  output logic [15:0] to_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RESP
  } state_t;

  localparam logic [LAT_W-1:0] TO = LAT_W'(TIMEOUT);

  state_t            state;
  logic [LAT_W-1:0]  wait_cnt;
  logic [DATA_W-1:0] tag;
  logic              go_q;
  logic              rdy_q;
  logic              vld_q;
  logic [LAT_W-1:0]  lat_q;
  logic              tmo_q;
  logic              hit;

  // change seen in the first ISSUE cycle is stale from the last op
  assign hit = b.change && (wait_cnt != '0);

  assign b.go          = go_q;
  assign b.req_ready   = rdy_q;
  assign b.rsp_valid   = vld_q;
  assign b.rsp_data    = tag;
  assign b.rsp_lat     = lat_q;
  assign b.rsp_timeout = tmo_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      wait_cnt <= '0;
      tag      <= '0;
      go_q     <= 1'b0;
      rdy_q    <= 1'b1;
      vld_q    <= 1'b0;
      lat_q    <= '0;
      tmo_q    <= 1'b0;
      busy     <= 1'b0;
      done_cnt <= '0;
      to_cnt   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (b.req_valid) begin
            tag      <= b.req_data;
            wait_cnt <= '0;
            state    <= ISSUE;
            go_q     <= 1'b1;
            rdy_q    <= 1'b0;
            busy     <= 1'b1;
          end
        end
        ISSUE: begin
          if (hit) begin
            state <= RESP;
            go_q  <= 1'b0;
            vld_q <= 1'b1;
            lat_q <= wait_cnt;
            tmo_q <= 1'b0;
            if (done_cnt != 16'hFFFF)
              done_cnt <= done_cnt + 16'd1;
          end else if (wait_cnt == TO) begin
            state <= RESP;
            go_q  <= 1'b0;
            vld_q <= 1'b1;
            lat_q <= TO;
            tmo_q <= 1'b1;
            if (to_cnt != 16'hFFFF)
              to_cnt <= to_cnt + 16'd1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        RESP: begin
          if (b.rsp_ready) begin
            state <= IDLE;
            vld_q <= 1'b0;
            rdy_q <= 1'b1;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          go_q  <= 1'b0;
          vld_q <= 1'b0;
          rdy_q <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mc_go_initiator.sv
// Directed bench for mc_go_initiator with a modelled
// delay-1 unit, a stuck-low unit and a stuck-high unit.
module tb_mc_go_initiator;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        busy;
  logic [15:0] done_cnt;
  logic [15:0] to_cnt;
  logic [1:0]  mode = 2'd0;
  logic        unit_q;

  int errs   = 0;
  int checks = 0;

  mc_go_if #(.DATA_W(32), .LAT_W(4)) b ();

  mc_go_initiator #(
    .DATA_W(32),
    .TIMEOUT(15),
    .LAT_W(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .b(b),
    .busy(busy),
    .done_cnt(done_cnt),
    .to_cnt(to_cnt)
  );

  always #5 clk = ~clk;

  // delay-1 unit: change follows go by one edge, drops once go falls
  always @(posedge clk or posedge rst) begin
    if (rst) unit_q <= 1'b0;
    else     unit_q <= b.go;
  end

  assign b.change = (mode == 2'd1) ? unit_q :
                    (mode == 2'd2);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [31:0] d0;
    logic        ok;
    int          n;
    int          cyc;
    int          last;
    int          ndone;
    int          nacc;
    int          lowrun;
    logic        seen;
    logic        prev_go;
    logic        low_ok;
    logic        per_ok;

    b.req_valid = 1'b0;
    b.req_data  = '0;
    b.rsp_ready = 1'b1;
    tick();
    tick();
    chk("rst_go",    32'(b.go),        32'd0);
    chk("rst_rdy",   32'(b.req_ready), 32'd1);
    chk("rst_vld",   32'(b.rsp_valid), 32'd0);
    chk("rst_data",  b.rsp_data,       32'd0);
    chk("rst_lat",   32'(b.rsp_lat),   32'd0);
    chk("rst_tmo",   32'(b.rsp_timeout), 32'd0);
    chk("rst_busy",  32'(busy),        32'd0);
    chk("rst_cnts",  {done_cnt, to_cnt}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // delay-1 unit
    tick();
    mode = 2'd1;
    b.req_valid = 1'b1;
    b.req_data  = 32'hA5A5_0001;
    tick();
    b.req_valid = 1'b0;
    chk("d1_go_n",   {30'd0, b.go, busy}, 32'd3);
    chk("d1_rdy_n",  32'(b.req_ready), 32'd0);
    tick();
    chk("d1_go_n1",  {30'd0, b.go, b.rsp_valid}, 32'd2);
    tick();
    chk("d1_go_n2",  {30'd0, b.go, b.rsp_valid}, 32'd1);
    chk("d1_lat",    32'(b.rsp_lat),   32'd1);
    chk("d1_tmo",    32'(b.rsp_timeout), 32'd0);
    chk("d1_data",   b.rsp_data,       32'hA5A5_0001);
    chk("d1_done",   32'(done_cnt),    32'd1);
    tick();
    chk("d1_back",   {30'd0, b.rsp_valid, b.req_ready}, 32'd1);

    // change stuck low: timeout
    mode = 2'd0;
    b.req_valid = 1'b1;
    b.req_data  = 32'h0000_0BAD;
    tick();
    b.req_valid = 1'b0;
    n = 1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (b.rsp_valid) break;
      if (b.go) n++;
    end
    chk("to_vld",    32'(b.rsp_valid), 32'd1);
    chk("to_gocyc",  32'(n),           32'd16);
    chk("to_flag",   32'(b.rsp_timeout), 32'd1);
    chk("to_lat",    32'(b.rsp_lat),   32'd15);
    chk("to_cnts",   {done_cnt, to_cnt}, {16'd1, 16'd1});
    tick();

    // change stuck high before request
    mode = 2'd2;
    tick();
    b.req_valid = 1'b1;
    b.req_data  = 32'h1234_5678;
    tick();
    b.req_valid = 1'b0;
    tick();
    chk("hi_first",  {30'd0, b.go, b.rsp_valid}, 32'd2);
    tick();
    chk("hi_vld",    32'(b.rsp_valid), 32'd1);
    chk("hi_lat",    32'(b.rsp_lat),   32'd1);
    chk("hi_tmo",    32'(b.rsp_timeout), 32'd0);
    chk("hi_cnts",   {done_cnt, to_cnt}, {16'd2, 16'd1});
    tick();

    // response back-pressure
    mode = 2'd1;
    tick();
    tick();
    b.rsp_ready = 1'b0;
    b.req_valid = 1'b1;
    b.req_data  = 32'hB0B0_0002;
    tick();
    b.req_data  = 32'hC0C0_0003;
    tick();
    tick();
    d0 = b.rsp_data;
    chk("bp_vld",    32'(b.rsp_valid), 32'd1);
    ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (!(b.rsp_valid && !b.req_ready && !b.go &&
            b.rsp_data == 32'hB0B0_0002 &&
            b.rsp_lat == 4'd1 && !b.rsp_timeout))
        ok = 1'b0;
    end
    chk("bp_hold",   32'(ok),          32'd1);
    chk("bp_data",   d0,               32'hB0B0_0002);
    b.rsp_ready = 1'b1;
    tick();
    chk("bp_idle",   {29'd0, b.rsp_valid, b.req_ready, b.go}, 32'd2);
    tick();
    b.req_valid = 1'b0;
    chk("bp_acc2",   32'(b.go),        32'd1);
    tick();
    tick();
    chk("bp_rsp2",   b.rsp_data,       32'hC0C0_0003);
    chk("bp_done",   32'(done_cnt),    32'd4);
    tick();

    // reset in ISSUE
    mode = 2'd0;
    b.req_valid = 1'b1;
    b.req_data  = 32'hDEAD_0005;
    tick();
    b.req_valid = 1'b0;
    tick();
    tick();
    tick();
    chk("rs_pre",    32'(b.go),        32'd1);
    rst = 1'b1;
    #1;
    chk("rs_go",     {29'd0, b.go, busy, b.rsp_valid}, 32'd0);
    chk("rs_cnts",   {done_cnt, to_cnt}, 32'd0);
    chk("rs_rdy",    32'(b.req_ready), 32'd1);
    tick();
    @(negedge clk);
    rst = 1'b0;
    mode = 2'd1;
    b.req_valid = 1'b1;
    b.req_data  = 32'h0000_0006;
    tick();
    b.req_valid = 1'b0;
    tick();
    tick();
    chk("rs_after",  {30'd0, b.rsp_valid, b.rsp_timeout}, 32'd2);
    chk("rs_lat",    32'(b.rsp_lat),   32'd1);
    chk("rs_done",   32'(done_cnt),    32'd1);
    tick();

    // 10 back-to-back with delay-1 unit
    rst = 1'b1;
    #1;
    tick();
    @(negedge clk);
    rst = 1'b0;
    b.req_valid = 1'b1;
    b.req_data  = 32'h0000_0100;
    ndone = 0;
    nacc  = 0;
    last  = 0;
    lowrun = 0;
    seen  = 1'b0;
    prev_go = 1'b0;
    low_ok = 1'b1;
    per_ok = 1'b1;
    cyc = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      cyc++;
      if (b.go && !prev_go) begin
        if (seen && lowrun < 2) low_ok = 1'b0;
        seen = 1'b1;
        nacc++;
        b.req_data = b.req_data + 32'd1;
        if (nacc == 10) b.req_valid = 1'b0;
      end
      lowrun = b.go ? 0 : lowrun + 1;
      prev_go = b.go;
      if (b.rsp_valid) begin
        if (ndone > 0 && cyc - last != 4) per_ok = 1'b0;
        last = cyc;
        ndone++;
        if (ndone == 10) break;
      end
    end
    chk("bb_ndone",  32'(ndone),       32'd10);
    chk("bb_lowgap", 32'(low_ok),      32'd1);
    chk("bb_period", 32'(per_ok),      32'd1);
    chk("bb_cnts",   {done_cnt, to_cnt}, {16'd10, 16'd0});
    tick();
    tick();
    chk("bb_idle",   {29'd0, b.go, busy, b.req_ready}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
